im2col_matmul_engine: RTL and testbench
=======================================

Name: im2col_matmul_engine

Overview:
Downstream stage of the 2-D im2col flattener. Consumes the flattened image matrix (KERNEL_SIZE² rows × OUTPUT_WIDTH columns) and the flattened kernel vector. Computes one convolution output per column as the dot product of that column with the kernel vector, using one serial multiply-accumulate (MAC) per cycle. Results stream out over a valid/ready interface in column order, index 0 first.

Parameters:
KERNEL_SIZE, 3, kernel side length; KK = KERNEL_SIZE² taps.
DATA_WIDTH, 8, unsigned element width of image and kernel.
OUTPUT_WIDTH, 324, number of im2col columns (18×18 for a 20×20 image, 3×3 kernel, stride 1, no padding).
ACC_WIDTH, 2*DATA_WIDTH+$clog2(KERNEL_SIZE*KERNEL_SIZE), accumulator and result width (default 20).
IDX_WIDTH, $clog2(OUTPUT_WIDTH), column index width (default 9).

Ports:
clk  in  1  clock; all logic on rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  single-cycle request to begin a full matrix pass.
image_im2col  in  [0:KK-1][0:OUTPUT_WIDTH-1][DATA_WIDTH-1:0]  flattened image; must stay stable while busy=1.
kernel_im2col  in  [0:KK-1][DATA_WIDTH-1:0]  flattened kernel; captured on accepted start.
busy  out  1  high from the accepted start until done.
out_valid  out  1  result available.
out_ready  in  1  downstream accepts the result.
out_data  out  ACC_WIDTH  dot product for column out_index.
out_index  out  IDX_WIDTH  column number of out_data.
done  out  1  one-cycle pulse after the last result handshake.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. busy, out_valid, out_data, out_index, done, tap counter, column counter, accumulator and kernel register all 0. Reset mid-pass aborts the pass with no further outputs.
- FSM states: IDLE, MAC, OUT, DONE.
- IDLE:
  - start=1 at edge E moves to MAC.
  - Same edge: capture kernel, col=0, tap=0, acc=0, busy=1.
  - start in any other state is ignored.
- MAC:
  - Each edge: acc += image_im2col[tap][col] * kreg[tap] (unsigned, full ACC_WIDTH, no overflow possible); tap++.
  - On the edge where tap==KK-1: out_data ← final sum, out_index ← col, out_valid=1, state OUT.
  - out_valid is therefore first visible KK cycles after E.
- OUT:
  - out_data and out_index are held stable while out_valid=1 and out_ready=0.
  - On the out_valid && out_ready edge:
    - out_valid=0.
    - If col==OUTPUT_WIDTH-1, go to DONE.
    - Otherwise col++, tap=0, acc=0, go to MAC.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE with done=0.
- Throughput with out_ready held at 1: KK+1 cycles per result; full pass OUTPUT_WIDTH×(KK+1) cycles, then the done cycle.
- out_ready while out_valid=0 has no effect.
- A start coincident with done (state DONE) is ignored; a new pass needs start in IDLE.
- Any image_im2col change while busy gives undefined results; kernel_im2col changes after start have no effect.

Test Plan:
1. Default params, kernel all 1, image all 2, start pulse, out_ready=1 -> 324 results each 18, out_index 0..323 in order. First out_valid exactly 9 cycles after the start edge. done pulses once, 324×10 cycles after start; busy low after.
2. Kernel all 255, image all 255 -> every out_data = 585225 (no truncation in 20 bits).
3. Identity kernel (tap 4 = 1, others 0), image_im2col[4][c] = c mod 256, other rows 0xFF -> out_data = c mod 256 for each column c.
4. Backpressure: out_ready low for 5 cycles when out_valid first rises -> out_valid, out_data, out_index=0 held unchanged. On the ready edge, advance; no results lost or duplicated across the pass.
5. start re-pulsed at cycle 20 of a pass, and kernel_im2col changed after start -> ignored; results match the original kernel, single done.
6. rst_n low during column 100 -> all outputs 0 asynchronously; after release, a fresh start restarts at out_index 0 with correct values.

Source files
------------

// File: rtl/im2col_matmul_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | im2col_matmul_engine                                                     |
// | Serial-MAC dot product of each im2col column with the kernel vector,     |
// | streamed out in column order over valid/ready.                           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module im2col_matmul_engine #(
  parameter int KERNEL_SIZE  = 3,
  parameter int DATA_WIDTH   = 8,
  parameter int OUTPUT_WIDTH = 324,
  parameter int ACC_WIDTH    = 2*DATA_WIDTH + $clog2(KERNEL_SIZE*KERNEL_SIZE),
  parameter int IDX_WIDTH    = $clog2(OUTPUT_WIDTH)
) (
  input  logic                                                                  clk,
  input  logic                                                                  rst_n,
  input  logic                                                                  start,
  input  logic [0:KERNEL_SIZE*KERNEL_SIZE-1][0:OUTPUT_WIDTH-1][DATA_WIDTH-1:0] image_im2col,
  input  logic [0:KERNEL_SIZE*KERNEL_SIZE-1][DATA_WIDTH-1:0]                   kernel_im2col,
  output logic                                                                  busy,
  output logic                                                                  out_valid,
  input  logic                                                                  out_ready,
  output logic [ACC_WIDTH-1:0]                                                  out_data,
  output logic [IDX_WIDTH-1:0]                                                  out_index,
  output logic                                                                  done
);

  localparam int C_KK    = KERNEL_SIZE*KERNEL_SIZE;
  localparam int C_TAP_W = (C_KK > 1) ? $clog2(C_KK) : 1;

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_MAC  = 2'd1;
  localparam logic [1:0] C_OUT  = 2'd2;
  localparam logic [1:0] C_DONE = 2'd3;

  localparam logic [C_TAP_W-1:0]   C_LAST_TAP = C_TAP_W'(C_KK-1);
  localparam logic [IDX_WIDTH-1:0] C_LAST_COL = IDX_WIDTH'(OUTPUT_WIDTH-1);

  logic [1:0]                      r_state;
  logic [C_TAP_W-1:0]              r_tap;
  logic [IDX_WIDTH-1:0]            r_col;
  logic [ACC_WIDTH-1:0]            r_acc;
  logic [0:C_KK-1][DATA_WIDTH-1:0] r_kreg;

  logic [DATA_WIDTH-1:0]   w_pix;
  logic [DATA_WIDTH-1:0]   w_coef;
  logic [2*DATA_WIDTH-1:0] w_prod;
  logic [ACC_WIDTH-1:0]    w_sum;

  assign w_pix  = image_im2col[r_tap][r_col];
  assign w_coef = r_kreg[r_tap];
  assign w_prod = {{DATA_WIDTH{1'b0}}, w_pix} * {{DATA_WIDTH{1'b0}}, w_coef};
  assign w_sum  = r_acc + ACC_WIDTH'(w_prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= C_IDLE;
      r_tap     <= '0;
      r_col     <= '0;
      r_acc     <= '0;
      r_kreg    <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        C_IDLE: begin
          if (start) begin
            r_kreg  <= kernel_im2col;
            r_col   <= '0;
            r_tap   <= '0;
            r_acc   <= '0;
            busy    <= 1'b1;
            r_state <= C_MAC;
          end
        end
        C_MAC: begin
          // The last tap's product goes straight into the result register.
          if (r_tap == C_LAST_TAP) begin
            out_data  <= w_sum;
            out_index <= r_col;
            out_valid <= 1'b1;
            r_state   <= C_OUT;
          end else begin
            r_acc <= w_sum;
            r_tap <= r_tap + C_TAP_W'(1);
          end
        end
        C_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (r_col == C_LAST_COL) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              r_state <= C_DONE;
            end else begin
              r_col   <= r_col + IDX_WIDTH'(1);
              r_tap   <= '0;
              r_acc   <= '0;
              r_state <= C_MAC;
            end
          end
        end
        C_DONE: r_state <= C_IDLE;
        default: r_state <= C_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_im2col_matmul_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_im2col_matmul_engine                                                  |
// | Scoreboard bench for the im2col dot-product engine.                      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_im2col_matmul_engine;

  localparam int KS = 3;
  localparam int DW = 8;
  localparam int OW = 324;
  localparam int KK = KS*KS;
  localparam int AW = 20;
  localparam int IW = 9;

  logic                           clk = 1'b0;
  logic                           rst_n = 1'b0;
  logic                           start = 1'b0;
  logic                           out_ready = 1'b1;
  logic [0:KK-1][0:OW-1][DW-1:0]  img;
  logic [0:KK-1][DW-1:0]          krn;
  logic                           busy;
  logic                           out_valid;
  logic                           done;
  logic [AW-1:0]                  out_data;
  logic [IW-1:0]                  out_index;

  typedef struct {
    int idx;
    int data;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_err  = 0;
  bit   mon_en = 1'b0;

  im2col_matmul_engine #(
    .KERNEL_SIZE (KS),
    .DATA_WIDTH  (DW),
    .OUTPUT_WIDTH(OW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .image_im2col (img),
    .kernel_im2col(krn),
    .busy         (busy),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_index    (out_index),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic build_expected();
    sb.delete();
    for (int c = 0; c < OW; c++) begin
      int s;
      s = 0;
      for (int t = 0; t < KK; t++) s += int'(img[t][c]) * int'(krn[t]);
      sb.push_back('{c, s});
    end
  endtask

  // Results are popped on the cycle whose rising edge completes the handshake.
  always begin
    @(negedge clk);
    #1;
    if (mon_en && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check_value("sb_nonempty", sb.size(), 1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_value("out_index", out_index, e.idx);
        check_value("out_data", out_data, e.data);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check_value({tag, "_busy"},  busy, 0);
    check_value({tag, "_valid"}, out_valid, 0);
    check_value({tag, "_data"},  out_data, 0);
    check_value({tag, "_index"}, out_index, 0);
    check_value({tag, "_done"},  done, 0);
  endtask

  task automatic run_pass(input int bp, input bit repulse, input int abort_at);
    bit fin;
    int exp0;
    int extra;
    build_expected();
    exp0      = sb[0].data;
    mon_en    = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_value("busy_on", busy, 1);
    fin = 1'b0;
    for (int k = 1; k <= OW*(KK+1) + 100 && !fin; k++) begin
      @(negedge clk);
      if (repulse && k == 2) krn = ~krn;
      start = (repulse && k == 20);
      if (k == KK-1) check_value("valid_early", out_valid, 0);
      if (k == KK)   check_value("valid_first", out_valid, 1);
      if (bp > 0 && k == KK) out_ready = 1'b0;
      if (bp > 0 && k > KK && k <= KK + bp) begin
        check_value("hold_valid", out_valid, 1);
        check_value("hold_data", out_data, exp0);
        check_value("hold_index", out_index, 0);
        if (k == KK + bp) out_ready = 1'b1;
      end
      if (abort_at > 0 && k == abort_at) begin
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check_all_zero("abort");
        fin = 1'b1;
      end else if (done) begin
        check_value("done_cycle", k, OW*(KK+1) + bp);
        check_value("busy_at_done", busy, 0);
        check_value("sb_left", sb.size(), 0);
        fin = 1'b1;
      end
    end
    check_value("pass_finished", fin, 1);
    if (abort_at > 0) begin
      @(negedge clk);
      rst_n = 1'b1;
      sb.delete();
    end else begin
      extra = 0;
      repeat (15) begin
        @(negedge clk);
        if (done || busy || out_valid) extra++;
      end
      check_value("idle_after", extra, 0);
    end
  endtask

  initial begin
    for (int t = 0; t < KK; t++) begin
      krn[t] = 8'd1;
      for (int c = 0; c < OW; c++) img[t][c] = 8'd2;
    end
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // All-ones kernel over a constant image.
    run_pass(0, 1'b0, 0);

    // Full-scale operands.
    for (int t = 0; t < KK; t++) begin
      krn[t] = 8'hFF;
      for (int c = 0; c < OW; c++) img[t][c] = 8'hFF;
    end
    run_pass(0, 1'b0, 0);

    // Identity kernel picks out the centre row.
    for (int t = 0; t < KK; t++) begin
      krn[t] = (t == 4) ? 8'd1 : 8'd0;
      for (int c = 0; c < OW; c++) img[t][c] = (t == 4) ? 8'(c % 256) : 8'hFF;
    end
    run_pass(0, 1'b0, 0);

    // Random data with backpressure on the first result.
    for (int t = 0; t < KK; t++) begin
      krn[t] = 8'($urandom_range(0, 255));
      for (int c = 0; c < OW; c++) img[t][c] = 8'($urandom_range(0, 255));
    end
    run_pass(5, 1'b0, 0);

    // Stray start and kernel change mid-pass.
    for (int t = 0; t < KK; t++) begin
      krn[t] = 8'($urandom_range(0, 255));
      for (int c = 0; c < OW; c++) img[t][c] = 8'($urandom_range(0, 255));
    end
    run_pass(0, 1'b1, 0);

    // Reset during column 100, then a clean pass.
    for (int t = 0; t < KK; t++) begin
      krn[t] = 8'($urandom_range(1, 255));
      for (int c = 0; c < OW; c++) img[t][c] = 8'($urandom_range(1, 255));
    end
    run_pass(0, 1'b0, 100*(KK+1) + 4);
    run_pass(0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
